mcu_block_sequencer: RTL and testbench

// - Read-side scheduler for the two-bank YCbCr MCU buffer; sits between buffer and DCT stage.
// - Tracks which bank holds a complete MCU and hands each full bank back to the writer when done.
// - Issues RAM read addresses for 8 blocks per MCU, in order Y0 Y1 Y2 Y3 Cb0 Cb1 Cr0 Cr1.
// - Tags the 64-sample block stream with component and frame markers for DCT/quant/entropy.

---
 rtl/mjpeg_pkg.sv | 29 ++
 rtl/mcu_block_sequencer_if.sv | 31 +++
 rtl/mcu_addr_gen.sv | 26 ++
 rtl/mcu_block_sequencer.sv | 127 ++++++++++++
 tb/tb_mcu_block_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mjpeg_pkg.sv
// Shared encodings and buffer geometry for the MJPEG MCU read path.
package mjpeg_pkg;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam int unsigned BANK_DEPTH  = 512;
    localparam int unsigned ADDR_W      = $clog2(BANK_DEPTH);
    localparam logic [8:0]  Y_BASE      = 9'd0;
    localparam logic [8:0]  CB_BASE     = 9'd256;
    localparam logic [8:0]  CR_BASE     = 9'd384;
    localparam int unsigned BLK_PER_MCU = 8;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_WAIT = 4'b0010,
        ST_READ = 4'b0100,
        ST_REL  = 4'b1000
    } seq_state_t;

    // Block order within an MCU: Y0..Y3, Cb0, Cb1, Cr0, Cr1
    function automatic logic [1:0] blk_comp(input logic [2:0] blk);
        if (!blk[2])     return COMP_Y;
        else if (!blk[1]) return COMP_CB;
        else              return COMP_CR;
    endfunction

endpackage

// File: rtl/mcu_block_sequencer_if.sv
// Buffer-write handshake, buffer read port and tagged block stream of the MCU sequencer.
interface mcu_block_sequencer_if;
    import mjpeg_pkg::*;

    logic              wr_done;
    logic              wr_bank;
    logic [1:0]        bank_full;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              dct_ready;
    logic              blk_valid;
    logic              blk_sop;
    logic              blk_eop;
    logic [1:0]        comp_id;
    logic              frame_end;
    logic              overflow;

    modport master (
        input  wr_done, wr_bank, dct_ready,
        output bank_full, rd_en, rd_bank, rd_addr,
        output blk_valid, blk_sop, blk_eop, comp_id, frame_end, overflow
    );

    modport slave (
        output wr_done, wr_bank, dct_ready,
        input  bank_full, rd_en, rd_bank, rd_addr,
        input  blk_valid, blk_sop, blk_eop, comp_id, frame_end, overflow
    );

endinterface

// File: rtl/mcu_addr_gen.sv
// Maps block index and in-block sample index (row/col raster) to a bank address and component.
module mcu_addr_gen
    import mjpeg_pkg::*;
(
    input  logic [2:0] blk_idx,
    input  logic [5:0] smp_idx,
    output logic [8:0] rd_addr,
    output logic [1:0] comp_id
);

    logic [2:0] row;
    logic [2:0] col;

    always_comb begin
        row     = smp_idx[5:3];
        col     = smp_idx[2:0];
        comp_id = blk_comp(blk_idx);
        case (comp_id)
            // Y is a 16-wide raster: blk[1] picks the lower half, blk[0] the right half
            COMP_Y:  rd_addr = Y_BASE  + {1'b0, blk_idx[1], row, blk_idx[0], col};
            COMP_CB: rd_addr = CB_BASE + {2'b00, blk_idx[0], row, col};
            default: rd_addr = CR_BASE + {2'b00, blk_idx[0], row, col};
        endcase
    end

endmodule

// File: rtl/mcu_block_sequencer.sv
// Read-side scheduler for the two-bank MCU buffer: bank ownership, block read sequencing
// and component/frame tagging of the 64-sample block stream towards the DCT.
module mcu_block_sequencer
    import mjpeg_pkg::*;
#(
    parameter int MCU_PER_FRAME = 1200,
    parameter int MCU_CNT_W     = 11
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    mcu_block_sequencer_if.master  bus
);

    seq_state_t           state_q, state_d;
    logic [5:0]           smp_q, smp_d;
    logic [2:0]           blk_q, blk_d;
    logic [MCU_CNT_W-1:0] mcu_q, mcu_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [1:0]           bank_full_q, bank_full_d;
    logic                 overflow_q, overflow_d;
    logic                 blk_valid_q, blk_valid_d;
    logic                 blk_sop_q, blk_sop_d;
    logic                 blk_eop_q, blk_eop_d;
    logic                 frame_end_q, frame_end_d;
    logic [1:0]           comp_id_q, comp_id_d;

    logic                 rd_en;
    logic                 last_smp, last_blk, last_mcu;
    logic [8:0]           gen_addr;
    logic [1:0]           gen_comp;

    mcu_addr_gen u_addr_gen (
        .blk_idx (blk_q),
        .smp_idx (smp_q),
        .rd_addr (gen_addr),
        .comp_id (gen_comp)
    );

    assign last_smp = (smp_q == 6'd63);
    assign last_blk = (blk_q == 3'(BLK_PER_MCU - 1));
    assign last_mcu = (mcu_q == MCU_CNT_W'(MCU_PER_FRAME - 1));

    always_comb begin
        state_d     = state_q;
        smp_d       = smp_q;
        blk_d       = blk_q;
        mcu_d       = mcu_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        overflow_d  = overflow_q;
        rd_en       = 1'b0;

        case (state_q)
            ST_IDLE: if (bank_full_q[rd_bank_q]) state_d = ST_WAIT;
            ST_WAIT: if (bus.dct_ready) state_d = ST_READ;
            ST_READ: begin
                rd_en = 1'b1;
                smp_d = smp_q + 6'd1;
                if (last_smp) begin
                    blk_d   = blk_q + 3'd1;
                    state_d = last_blk ? ST_REL : ST_WAIT;
                end
            end
            ST_REL: begin
                bank_full_d[rd_bank_q] = 1'b0;
                rd_bank_d              = ~rd_bank_q;
                mcu_d                  = last_mcu ? '0 : mcu_q + 1'b1;
                state_d                = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Applied after the release so a same-cycle write to the released bank keeps it full
        if (bus.wr_done) begin
            if (bank_full_q[bus.wr_bank]) overflow_d = 1'b1;
            bank_full_d[bus.wr_bank] = 1'b1;
        end

        blk_valid_d = rd_en;
        blk_sop_d   = rd_en && (smp_q == 6'd0);
        blk_eop_d   = rd_en && last_smp;
        frame_end_d = rd_en && last_smp && last_blk && last_mcu;
        comp_id_d   = rd_en ? gen_comp : comp_id_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            smp_q       <= '0;
            blk_q       <= '0;
            mcu_q       <= '0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= '0;
            overflow_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_sop_q   <= 1'b0;
            blk_eop_q   <= 1'b0;
            frame_end_q <= 1'b0;
            comp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            smp_q       <= smp_d;
            blk_q       <= blk_d;
            mcu_q       <= mcu_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            overflow_q  <= overflow_d;
            blk_valid_q <= blk_valid_d;
            blk_sop_q   <= blk_sop_d;
            blk_eop_q   <= blk_eop_d;
            frame_end_q <= frame_end_d;
            comp_id_q   <= comp_id_d;
        end
    end

    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = rd_en ? gen_addr : '0;
    assign bus.rd_bank   = rd_bank_q;
    assign bus.bank_full = bank_full_q;
    assign bus.overflow  = overflow_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_sop   = blk_sop_q;
    assign bus.blk_eop   = blk_eop_q;
    assign bus.frame_end = frame_end_q;
    assign bus.comp_id   = comp_id_q;

endmodule

// File: tb/tb_mcu_block_sequencer.sv
// Directed bench for mcu_block_sequencer with a two-MCU frame.
module tb_mcu_block_sequencer;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] exp_full;
    logic       exp_ovf;
    int         mcu_idx;
    int         fe_cnt;
    int         fe0;
    int         nwait;

    mcu_block_sequencer_if bus ();

    mcu_block_sequencer #(
        .MCU_PER_FRAME (2),
        .MCU_CNT_W     (1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int b, input int s);
        int r = s / 8;
        int c = s % 8;
        if (b < 4)      return ((b / 2) * 8 + r) * 16 + (b % 2) * 8 + c;
        else if (b < 6) return 256 + ((b - 4) * 8 + r) * 8 + c;
        else            return 384 + ((b - 6) * 8 + r) * 8 + c;
    endfunction

    function automatic int exp_comp(input int b);
        return (b < 4) ? 0 : ((b < 6) ? 1 : 2);
    endfunction

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_rd_en"},     bus.rd_en,     0);
        chk({pfx, "_rd_addr"},   bus.rd_addr,   0);
        chk({pfx, "_rd_bank"},   bus.rd_bank,   0);
        chk({pfx, "_bank_full"}, bus.bank_full, 0);
        chk({pfx, "_blk_valid"}, bus.blk_valid, 0);
        chk({pfx, "_blk_sop"},   bus.blk_sop,   0);
        chk({pfx, "_blk_eop"},   bus.blk_eop,   0);
        chk({pfx, "_comp_id"},   bus.comp_id,   0);
        chk({pfx, "_frame_end"}, bus.frame_end, 0);
        chk({pfx, "_overflow"},  bus.overflow,  0);
    endtask

    task automatic pulse_wr(input logic b);
        bus.wr_done = 1'b1;
        bus.wr_bank = b;
        if (exp_full[b]) exp_ovf = 1'b1;
        exp_full[b] = 1'b1;
        @(negedge sys_clk);
        bus.wr_done = 1'b0;
    endtask

    // Returns on the cycle after the block's last read (eop visible on the stream side).
    task automatic run_block(input int b, input logic bank, input int wr_at, input logic wr_b,
                             input bit drop_dct, input bit toggle_dct);
        int n = 0;
        while (bus.rd_en !== 1'b1 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        chk("blk_start", bus.rd_en, 1);
        for (int s = 0; s < 64; s++) begin
            chk("rd_en", bus.rd_en, 1);
            chk("rd_addr", bus.rd_addr, exp_addr(b, s));
            chk("rd_bank", bus.rd_bank, bank);
            if (s == 0) begin
                chk("valid_gap", bus.blk_valid, 0);
            end else begin
                chk("blk_valid", bus.blk_valid, 1);
                chk("blk_sop", bus.blk_sop, s == 1);
                chk("blk_eop_mid", bus.blk_eop, 0);
                chk("comp_id", bus.comp_id, exp_comp(b));
                chk("frame_end_mid", bus.frame_end, 0);
            end
            if (s == wr_at) begin
                bus.wr_done = 1'b1;
                bus.wr_bank = wr_b;
                if (exp_full[wr_b]) exp_ovf = 1'b1;
                exp_full[wr_b] = 1'b1;
            end else begin
                bus.wr_done = 1'b0;
            end
            if (toggle_dct && s == 10) bus.dct_ready = 1'b0;
            if (toggle_dct && s == 40) bus.dct_ready = 1'b1;
            if (drop_dct && s == 63)   bus.dct_ready = 1'b0;
            @(negedge sys_clk);
        end
        chk("rd_en_gap", bus.rd_en, 0);
        chk("eop_valid", bus.blk_valid, 1);
        chk("blk_eop", bus.blk_eop, 1);
        chk("eop_sop", bus.blk_sop, 0);
        chk("eop_comp_id", bus.comp_id, exp_comp(b));
        chk("frame_end", bus.frame_end, (b == 7) && (mcu_idx == 1));
        chk("overflow", bus.overflow, exp_ovf);
        chk("bank_full", bus.bank_full, exp_full);
        if (bus.frame_end === 1'b1) fe_cnt++;
    endtask

    task automatic run_mcu(input logic bank, input int wr_blk, input logic wr_b, input int stall_blk);
        for (int b = 0; b < 8; b++) begin
            run_block(b, bank, (b == wr_blk) ? 5 : -1, wr_b,
                      (stall_blk != 0) && (b + 1 == stall_blk),
                      (stall_blk != 0) && (b == stall_blk));
            if ((stall_blk != 0) && (b + 1 == stall_blk)) begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge sys_clk);
                    chk("bp_rd_en", bus.rd_en, 0);
                    chk("bp_valid", bus.blk_valid, 0);
                end
                bus.dct_ready = 1'b1;
                @(negedge sys_clk);
                chk("bp_latency", bus.rd_en, 1);
            end
        end
        @(negedge sys_clk);
        exp_full[bank] = 1'b0;
        chk("bank_full_rel", bus.bank_full, exp_full);
        chk("rd_bank_toggle", bus.rd_bank, !bank);
        mcu_idx = (mcu_idx + 1) % 2;
    endtask

    initial begin
        bus.wr_done   = 1'b0;
        bus.wr_bank   = 1'b0;
        bus.dct_ready = 1'b1;
        exp_full      = 2'b00;
        exp_ovf       = 1'b0;
        mcu_idx       = 0;
        fe_cnt        = 0;

        repeat (2) @(negedge sys_clk);
        chk_all_zero("reset");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Single MCU in bank 0
        pulse_wr(1'b0);
        chk("bank_full_set", bus.bank_full, 2'b01);
        run_mcu(1'b0, -1, 1'b0, 0);

        // Ping-pong: bank 0 refilled while bank 1 is read
        pulse_wr(1'b1);
        run_mcu(1'b1, 2, 1'b0, 0);
        run_mcu(1'b0, -1, 1'b0, 0);

        // Backpressure before block 3, dct_ready toggled inside block 3
        pulse_wr(1'b1);
        run_mcu(1'b1, -1, 1'b0, 3);

        // Overflow: second write to bank 0 while it is still full
        pulse_wr(1'b0);
        chk("ovf_clear", bus.overflow, 0);
        run_mcu(1'b0, 1, 1'b0, 0);
        chk("ovf_set", bus.overflow, 1);
        pulse_wr(1'b1);
        run_mcu(1'b1, -1, 1'b0, 0);
        chk("ovf_sticky", bus.overflow, 1);

        // Full frame of two MCUs
        fe0 = fe_cnt;
        pulse_wr(1'b0);
        run_mcu(1'b0, 4, 1'b1, 0);
        run_mcu(1'b1, -1, 1'b0, 0);
        chk("frame_end_count", fe_cnt - fe0, 1);

        // Asynchronous reset during block 5 sample 30
        pulse_wr(1'b0);
        for (int b = 0; b < 5; b++) run_block(b, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        nwait = 0;
        while (bus.rd_en !== 1'b1 && nwait < 200) begin
            @(negedge sys_clk);
            nwait++;
        end
        chk("blk5_start", bus.rd_en, 1);
        repeat (30) @(negedge sys_clk);
        chk("blk5_s30_addr", bus.rd_addr, exp_addr(5, 30));
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        exp_full  = 2'b00;
        exp_ovf   = 1'b0;
        mcu_idx   = 0;
        @(negedge sys_clk);
        chk("no_restart", bus.rd_en, 0);
        pulse_wr(1'b0);
        run_mcu(1'b0, -1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
